mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

Memory bus sequencer sitting directly downstream of the multi-cycle CPU datapath. It consumes the datapath's memory address bus (MAB) and owns the timing of every memory read and write. It asserts the external memory strobes and enables for the bidirectional MDB, and tells the control unit when data is ready to load into MDR. It also enforces word alignment and a ready-timeout, so a stalled or misaddressed access cannot hang the control FSM.

## Interface
Parameters:
- MIN_WAIT, default 0: minimum number of ACCESS cycles beyond the first before completion is allowed (0..TIMEOUT-2).
- TIMEOUT, default 16: ACCESS cycles allowed before abort (2..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- rd_req  in  1  read request from control unit, sampled in IDLE only.
- wr_req  in  1  write request from control unit, sampled in IDLE only.
- MAB  in  16  address from datapath MAR.
- mem_ready  in  1  memory ready/acknowledge.
- mem_addr  out  16  latched address to memory.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mdb_oe  out  1  enables the datapath MDR to drive MDB (write cycles).
- ld_mdb  out  1  load MDR from MDB (read completion).
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- bus_err  out  1  one-cycle error pulse.
- err_code  out  2  last error: 00 none, 01 odd address, 10 timeout, 11 rd/wr conflict.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RECOVER. A cycle counter cnt is 8 bits wide.
- IDLE: busy=0, all strobes low. Request handling when sampled:
  - rd_req & wr_req: bus_err=1, err_code<=11, stay IDLE.
  - Request with MAB[0]=1: bus_err=1, err_code<=01, stay IDLE.
  - Valid request: mem_addr<=MAB, latch op, err_code<=00, go to SETUP.
  - No request: stay IDLE.
- SETUP: busy=1, strobes low, mdb_oe=1 if write. Go to ACCESS and set cnt<=0.
- ACCESS: busy=1, mem_rd or mem_wr held high, mdb_oe=1 for write.
  - Completion condition: mem_ready & (cnt>=MIN_WAIT).
  - On completion, in the same cycle (Mealy): done=1; for a read, also ld_mdb=1. Next state is RECOVER.
  - Else if cnt==TIMEOUT-1: bus_err=1, err_code<=10, no ld_mdb or done, go to RECOVER.
  - Else cnt<=cnt+1.
- RECOVER: busy=1, strobes low, mdb_oe=0. Go to IDLE.
- mem_addr holds its value from acceptance until the next accepted request.
- rd_req and wr_req outside IDLE are ignored. The control unit waits for done or bus_err before issuing a new request.
- mem_rd, mem_wr and mdb_oe are never high in IDLE or RECOVER.
- mem_rd and mem_wr are never high together.

## Timing
- Reset values: state=IDLE, mem_addr=0, cnt=0, err_code=00. All 1-bit outputs are 0.
- Reset applied mid-transaction drops the strobes and mdb_oe immediately, without waiting for clk.
- Request sampled at edge 0 → SETUP in cycle 1 → ACCESS from cycle 2.
- Best case (MIN_WAIT=0, mem_ready high): done in cycle 2, RECOVER in cycle 3, a new request is accepted at the end of cycle 4's IDLE.
- General case: done occurs in cycle 2+max(MIN_WAIT, k), where k is the first ACCESS index with mem_ready high.
- Timeout: bus_err occurs in cycle 2+TIMEOUT-1 when mem_ready never qualifies.
- mem_ready arriving in the same cycle as cnt==TIMEOUT-1 with cnt>=MIN_WAIT counts as completion. Completion takes priority over timeout.
- mem_ready is ignored outside ACCESS.
- done, ld_mdb and bus_err are exactly one cycle wide, and done and bus_err are never high together.

## Test plan
- Read, MIN_WAIT=0: rd_req with MAB=0x0040, mem_ready=1 → mem_addr=0x0040, mem_rd high in cycle 2 only, done and ld_mdb in cycle 2, busy low in cycle 4.
- Write with wait states, MIN_WAIT=2: wr_req with MAB=0x1234, mem_ready=1 → mdb_oe high cycles 1–4, mem_wr high cycles 2–4, done in cycle 4, ld_mdb never asserted.
- Errors: MAB=0x0003 with rd_req → bus_err in cycle 0, err_code=01, no strobes. Both rd_req and wr_req → err_code=11.
- Timeout, TIMEOUT=16: mem_ready held at 0 → bus_err in cycle 17, err_code=10, strobes low from cycle 18, IDLE in cycle 19.
- Boundary and reset: mem_ready rising at cnt=15 → done, not bus_err. rst pulsed mid-ACCESS → mem_rd falls asynchronously and all outputs return to reset values. Requests held during busy are not double-accepted.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: memory bus sequencer for the multi-cycle CPU datapath.
//
// This block takes the address on MAB and runs one memory read or write.
// It drives the memory strobes and the MDB output enable, and it tells the
// control unit when MDR can be loaded. A request with an odd address, or
// with both read and write set, is rejected. An access that never gets
// mem_ready is aborted after TIMEOUT ACCESS cycles.
//
// Sequence: IDLE -> SETUP -> ACCESS (one or more cycles) -> RECOVER -> IDLE
//
// Parameters:
//   MIN_WAIT  ACCESS cycles beyond the first before completion is allowed
//   TIMEOUT   ACCESS cycles allowed before the access is aborted
//
// Ports:
//   clk, rst          clock (rising edge); asynchronous active-high reset
//   rd_req, wr_req    requests from the control unit, sampled in IDLE only
//   MAB               address from the datapath MAR
//   mem_ready         memory acknowledge, only looked at in ACCESS
//   mem_addr          address latched when a request is accepted
//   mem_rd, mem_wr    memory strobes, high only during ACCESS
//   mdb_oe            lets MDR drive MDB during SETUP/ACCESS of a write
//   ld_mdb            load MDR from MDB in the cycle a read completes
//   busy              a transaction is in progress (SETUP..RECOVER)
//   done, bus_err     one-cycle completion / error pulses
//   err_code          last error: 00 none, 01 odd, 10 timeout, 11 conflict
module mem_bus_ctrl #(
    parameter int MIN_WAIT = 0,
    parameter int TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [15:0] MAB,
    input  logic        mem_ready,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mdb_oe,
    output logic        ld_mdb,
    output logic        busy,
    output logic        done,
    output logic        bus_err,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RECOVER = 2'd3
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       op_rd;

    logic in_idle;
    logic req_conflict;
    logic req_odd;
    logic req_ok;
    logic wait_met;
    logic complete;
    logic timeout_hit;

    // With MIN_WAIT of zero every ACCESS cycle may complete. The comparison
    // is only built when it can actually be false.
    generate
        if (MIN_WAIT == 0) begin : g_no_wait
            assign wait_met = 1'b1;
        end else begin : g_min_wait
            assign wait_met = (cnt >= 8'(MIN_WAIT));
        end
    endgenerate

    assign in_idle      = (state == IDLE);
    assign req_conflict = in_idle & rd_req & wr_req;
    assign req_odd      = in_idle & (rd_req ^ wr_req) & MAB[0];
    assign req_ok       = in_idle & (rd_req ^ wr_req) & ~MAB[0];

    // Completion has priority over timeout when both happen in the last cycle.
    assign complete    = (state == ACCESS) & mem_ready & wait_met;
    assign timeout_hit = (state == ACCESS) & ~complete & (cnt == LAST_CNT);

    // The pulses are Mealy outputs, so they react in the same cycle.
    // They are gated with rst so that a bad request present while reset is
    // held cannot raise bus_err.
    assign done    = complete & ~rst;
    assign ld_mdb  = complete & op_rd & ~rst;
    assign bus_err = (req_conflict | req_odd | timeout_hit) & ~rst;

    // Strobes, mdb_oe and busy are registers written together with the state.
    // Reset clears them at once, which drops the bus even in the middle of
    // a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            op_rd    <= 1'b0;
            mem_addr <= 16'd0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            mdb_oe   <= 1'b0;
            busy     <= 1'b0;
            err_code <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_conflict) begin
                        err_code <= 2'b11;
                    end else if (req_odd) begin
                        err_code <= 2'b01;
                    end else if (req_ok) begin
                        mem_addr <= MAB;
                        op_rd    <= rd_req;
                        err_code <= 2'b00;
                        mdb_oe   <= wr_req;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    cnt    <= 8'd0;
                    mem_rd <= op_rd;
                    mem_wr <= ~op_rd;
                    state  <= ACCESS;
                end
                ACCESS: begin
                    if (complete || timeout_hit) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        mdb_oe <= 1'b0;
                        state  <= RECOVER;
                        if (timeout_hit) begin
                            err_code <= 2'b10;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RECOVER: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Testbench for mem_bus_ctrl.
// Two instances are used. dut_a has MIN_WAIT=0 and dut_w has MIN_WAIT=2.
// Both have TIMEOUT=16.
// Each transaction records one bit per cycle for every output.
// The expected record is pushed to a queue when stimulus starts.
// It is popped and compared when the transaction window ends.
module tb_mem_bus_ctrl;

    typedef struct packed {
        logic [31:0] rd;
        logic [31:0] wr;
        logic [31:0] oe;
        logic [31:0] dn;
        logic [31:0] ld;
        logic [31:0] er;
        logic [31:0] bz;
        logic [15:0] addr;
        logic [1:0]  ec;
    } trace_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_rd_req, a_wr_req, a_mem_ready;
    logic [15:0] a_mab;
    logic [15:0] a_mem_addr;
    logic        a_mem_rd, a_mem_wr, a_mdb_oe, a_ld_mdb, a_busy, a_done, a_bus_err;
    logic [1:0]  a_err_code;

    logic        w_rd_req, w_wr_req, w_mem_ready;
    logic [15:0] w_mab;
    logic [15:0] w_mem_addr;
    logic        w_mem_rd, w_mem_wr, w_mdb_oe, w_ld_mdb, w_busy, w_done, w_bus_err;
    logic [1:0]  w_err_code;

    int n_checks = 0;
    int n_fail   = 0;

    trace_t      exp_q[$];
    logic [15:0] prev_addr[2];
    logic [1:0]  prev_ec[2];

    mem_bus_ctrl #(.MIN_WAIT(0), .TIMEOUT(16)) dut_a (
        .clk(clk), .rst(rst), .rd_req(a_rd_req), .wr_req(a_wr_req), .MAB(a_mab),
        .mem_ready(a_mem_ready), .mem_addr(a_mem_addr), .mem_rd(a_mem_rd),
        .mem_wr(a_mem_wr), .mdb_oe(a_mdb_oe), .ld_mdb(a_ld_mdb), .busy(a_busy),
        .done(a_done), .bus_err(a_bus_err), .err_code(a_err_code)
    );

    mem_bus_ctrl #(.MIN_WAIT(2), .TIMEOUT(16)) dut_w (
        .clk(clk), .rst(rst), .rd_req(w_rd_req), .wr_req(w_wr_req), .MAB(w_mab),
        .mem_ready(w_mem_ready), .mem_addr(w_mem_addr), .mem_rd(w_mem_rd),
        .mem_wr(w_mem_wr), .mdb_oe(w_mdb_oe), .ld_mdb(w_ld_mdb), .busy(w_busy),
        .done(w_done), .bus_err(w_bus_err), .err_code(w_err_code)
    );

    function automatic logic [31:0] span(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Expected trace from the timing rules:
    // - A bad request pulses bus_err in cycle 0 and nothing else happens.
    // - A valid one completes in cycle 2+max(MIN_WAIT,k) if that is within
    //   the 16 ACCESS cycles.
    // - Otherwise it times out in cycle 17.
    function automatic trace_t model(input int minw, input bit r, input bit w,
                                     input logic [15:0] a, input int k,
                                     input logic [15:0] pa, input logic [1:0] pe);
        trace_t t;
        int     keff;
        int     d;
        bit     comp;
        t = '0;
        if (r && w) begin
            t.er = 32'h1; t.addr = pa; t.ec = 2'b11;
        end else if (a[0]) begin
            t.er = 32'h1; t.addr = pa; t.ec = 2'b01;
        end else begin
            keff = (k < 0) ? 99 : ((k > minw) ? k : minw);
            comp = (keff <= 15);
            d    = comp ? 2 + keff : 17;
            if (r) t.rd = span(2, d);
            if (w) begin
                t.wr = span(2, d);
                t.oe = span(1, d);
            end
            t.bz   = span(1, d + 1);
            t.dn[d] = comp;
            t.ld[d] = comp & r;
            t.er[d] = ~comp;
            t.addr = a;
            t.ec   = comp ? 2'b00 : 2'b10;
        end
        return t;
    endfunction

    // Drives one request and records n cycles of outputs.
    // - The request is held for cycle 0 only.
    // - With hold set, it stays up until done or bus_err is seen.
    // - mem_ready goes high from ACCESS index k onward; k<0 means never.
    task automatic run_access(input bit sel_w, input bit r, input bit w,
                              input logic [15:0] a, input int k, input int n,
                              input bit hold, output trace_t t);
        bit seen;
        seen = 1'b0;
        t = '0;
        for (int c = 0; c < n; c++) begin
            logic rq;
            logic rdy;
            rq  = (c == 0) || (hold && !seen);
            rdy = (k >= 0) && (c >= 2 + k);
            if (sel_w) begin
                w_rd_req = rq & r; w_wr_req = rq & w; w_mab = a; w_mem_ready = rdy;
            end else begin
                a_rd_req = rq & r; a_wr_req = rq & w; a_mab = a; a_mem_ready = rdy;
            end
            #1;
            t.rd[c] = sel_w ? w_mem_rd  : a_mem_rd;
            t.wr[c] = sel_w ? w_mem_wr  : a_mem_wr;
            t.oe[c] = sel_w ? w_mdb_oe  : a_mdb_oe;
            t.dn[c] = sel_w ? w_done    : a_done;
            t.ld[c] = sel_w ? w_ld_mdb  : a_ld_mdb;
            t.er[c] = sel_w ? w_bus_err : a_bus_err;
            t.bz[c] = sel_w ? w_busy    : a_busy;
            if (t.dn[c] || t.er[c]) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        t.addr = sel_w ? w_mem_addr : a_mem_addr;
        t.ec   = sel_w ? w_err_code : a_err_code;
        a_rd_req = 1'b0; a_wr_req = 1'b0; a_mem_ready = 1'b0;
        w_rd_req = 1'b0; w_wr_req = 1'b0; w_mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_rd_req = 1'b1; a_wr_req = 1'b1; a_mab = 16'h0000; a_mem_ready = 1'b1;
        w_rd_req = 1'b0; w_wr_req = 1'b0; w_mab = 16'h0000; w_mem_ready = 1'b0;
        #1;
        n_checks++;
        if (a_mem_addr !== 16'h0000 || a_err_code !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_regs: got addr=%h ec=%b expected addr=0000 ec=00", a_mem_addr, a_err_code);
        end
        n_checks++;
        if ({a_mem_rd, a_mem_wr, a_mdb_oe, a_ld_mdb, a_busy, a_done, a_bus_err} !== 7'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_bits: got %b expected 0000000",
                     {a_mem_rd, a_mem_wr, a_mdb_oe, a_ld_mdb, a_busy, a_done, a_bus_err});
        end
        n_checks++;
        if ({w_mem_addr, w_err_code, w_mem_rd, w_mem_wr, w_mdb_oe, w_busy} !== 22'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_w: got addr=%h ec=%b bits=%b expected all zero",
                     w_mem_addr, w_err_code, {w_mem_rd, w_mem_wr, w_mdb_oe, w_busy});
        end
        a_rd_req = 1'b0; a_wr_req = 1'b0; a_mem_ready = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (a_busy !== 1'b0 || a_err_code !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_release: got busy=%b ec=%b expected busy=0 ec=00", a_busy, a_err_code);
        end
        prev_addr[0] = 16'h0; prev_addr[1] = 16'h0;
        prev_ec[0] = 2'b00;   prev_ec[1] = 2'b00;
    endtask

    // Runs a list of transactions through the scoreboard.
    // Each one gets three comparisons.
    task automatic test_transfers(input string name, input bit sel_w, input bit r[],
                                  input bit w[], input logic [15:0] a[], input int k[],
                                  input int n[], input bit hold);
        trace_t got, e;
        int     sel;
        sel = sel_w ? 1 : 0;
        for (int i = 0; i < a.size(); i++) begin
            exp_q.push_back(model(sel_w ? 2 : 0, r[i], w[i], a[i], k[i], prev_addr[sel], prev_ec[sel]));
            run_access(sel_w, r[i], w[i], a[i], k[i], n[i], hold, got);
            e = exp_q.pop_front();
            prev_addr[sel] = e.addr;
            prev_ec[sel]   = e.ec;
            n_checks++;
            if ({got.rd, got.wr, got.oe} !== {e.rd, e.wr, e.oe}) begin
                n_fail++;
                $display("[TB] FAIL %s[%0d] strobes: got rd=%h wr=%h oe=%h expected rd=%h wr=%h oe=%h",
                         name, i, got.rd, got.wr, got.oe, e.rd, e.wr, e.oe);
            end
            n_checks++;
            if ({got.dn, got.ld, got.er, got.bz} !== {e.dn, e.ld, e.er, e.bz}) begin
                n_fail++;
                $display("[TB] FAIL %s[%0d] handshake: got done=%h ld=%h err=%h busy=%h expected done=%h ld=%h err=%h busy=%h",
                         name, i, got.dn, got.ld, got.er, got.bz, e.dn, e.ld, e.er, e.bz);
            end
            n_checks++;
            if ({got.addr, got.ec} !== {e.addr, e.ec}) begin
                n_fail++;
                $display("[TB] FAIL %s[%0d] addr_code: got addr=%h ec=%b expected addr=%h ec=%b",
                         name, i, got.addr, got.ec, e.addr, e.ec);
            end
        end
    endtask

    task automatic test_read();
        test_transfers("read", 1'b0, '{1, 1}, '{0, 0}, '{16'h0040, 16'h8000}, '{0, 3}, '{6, 8}, 1'b0);
    endtask

    task automatic test_write_wait();
        test_transfers("write_wait", 1'b1, '{0, 0}, '{1, 1}, '{16'h1234, 16'hFFFE}, '{0, 5}, '{7, 10}, 1'b0);
    endtask

    task automatic test_errors();
        test_transfers("errors", 1'b0, '{1, 0, 1, 1}, '{0, 1, 1, 0},
                       '{16'h0003, 16'h0101, 16'h0200, 16'h0ACE}, '{0, 0, 0, 1}, '{2, 2, 2, 7}, 1'b0);
    endtask

    task automatic test_timeout_boundary();
        test_transfers("timeout", 1'b0, '{1, 1}, '{0, 0}, '{16'h4000, 16'h4002}, '{-1, 15}, '{21, 21}, 1'b0);
        test_transfers("timeout_w", 1'b1, '{0}, '{1}, '{16'h0010}, '{15}, '{21}, 1'b0);
    endtask

    task automatic test_back_to_back();
        test_transfers("back_to_back", 1'b0, '{1, 0, 1}, '{0, 1, 0},
                       '{16'h2000, 16'h2002, 16'h2004}, '{0, 0, 1}, '{4, 4, 6}, 1'b1);
    endtask

    task automatic test_reset_mid();
        a_rd_req = 1'b1; a_wr_req = 1'b0; a_mab = 16'h0100; a_mem_ready = 1'b0;
        @(posedge clk); #1;
        a_rd_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (a_mem_rd !== 1'b1 || a_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_active: got rd=%b busy=%b expected rd=1 busy=1", a_mem_rd, a_busy);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({a_mem_rd, a_mem_wr, a_mdb_oe, a_busy, a_done, a_ld_mdb, a_bus_err} !== 7'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_bits: got %b expected 0000000",
                     {a_mem_rd, a_mem_wr, a_mdb_oe, a_busy, a_done, a_ld_mdb, a_bus_err});
        end
        n_checks++;
        if (a_mem_addr !== 16'h0000 || a_err_code !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_regs: got addr=%h ec=%b expected addr=0000 ec=00", a_mem_addr, a_err_code);
        end
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        prev_addr[0] = 16'h0; prev_addr[1] = 16'h0;
        prev_ec[0] = 2'b00;   prev_ec[1] = 2'b00;
        test_transfers("after_reset", 1'b0, '{1}, '{0}, '{16'h0C00}, '{2}, '{7}, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_read();
        test_errors();
        test_write_wait();
        test_timeout_boundary();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
